mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 13 +
 rtl/mul_arbiter_multiplier_reg.sv | 30 +++
 rtl/mul_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: state encoding and
// default operand/requester sizing.
package mul_arbiter_pkg;

    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_NUM_REQ  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/mul_arbiter_multiplier_reg.sv
// Registered unsigned multiplier shared by all requesters; clear wins over enable,
// otherwise the product holds.
module multiplier_reg #(
    parameter int BITWIDTH = 8
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iEn,
    input  logic                  iClr,
    input  logic [BITWIDTH-1:0]   iA,
    input  logic [BITWIDTH-1:0]   iB,
    output logic [2*BITWIDTH-1:0] oProd
);

    localparam int PW = 2 * BITWIDTH;

    // product register: full-width unsigned multiply on enable
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oProd <= '0;
        end else if (iClr) begin
            oProd <= '0;
        end else if (iEn) begin
            oProd <= PW'(iA) * PW'(iB);
        end else begin
            oProd <= oProd;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter in front of one shared registered multiplier; a single
// response slot that can be refilled in the same cycle it drains.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iFlush,
    input  logic [NUM_REQ-1:0]           iReqValid,
    input  logic [NUM_REQ*BITWIDTH-1:0]  iReqData0,
    input  logic [NUM_REQ*BITWIDTH-1:0]  iReqData1,
    output logic [NUM_REQ-1:0]           oReqReady,
    output logic                         oRspValid,
    output logic [IDW-1:0]               oRspId,
    output logic [2*BITWIDTH-1:0]        oRspData,
    input  logic                         iRspReady,
    output logic                         oBusy,
    output logic [15:0]                  oDoneCnt
);

    state_t               state_r;
    state_t               stateNext_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       grantIdx_s;
    logic [IDW-1:0]       probe_s;
    logic                 anyValid_s;
    logic                 slotFree_s;
    logic                 accept_s;
    logic                 complete_s;
    logic [BITWIDTH-1:0]  opA_s;
    logic [BITWIDTH-1:0]  opB_s;

    // round-robin search: walk offsets high to low so the nearest valid requester wins
    always_comb begin
        grantIdx_s = ptr_r;
        anyValid_s = 1'b0;
        probe_s    = ptr_r;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            probe_s = ptr_r + IDW'(i);
            if (iReqValid[probe_s]) begin
                grantIdx_s = probe_s;
                anyValid_s = 1'b1;
            end else begin
                anyValid_s = anyValid_s;
            end
        end
    end

    // grant/accept and operand mux; reset and flush both block any grant
    always_comb begin
        slotFree_s = iRstN && !iFlush && ((state_r == IDLE) || iRspReady);
        accept_s   = slotFree_s && anyValid_s;
        complete_s = (state_r == RESP) && iRspReady && !iFlush;
        opA_s      = iReqData0[grantIdx_s*BITWIDTH +: BITWIDTH];
        opB_s      = iReqData1[grantIdx_s*BITWIDTH +: BITWIDTH];
        if (accept_s) begin
            oReqReady = {{(NUM_REQ-1){1'b0}}, 1'b1} << grantIdx_s;
        end else begin
            oReqReady = '0;
        end
    end

    // next-state: flush first, then a new accept keeps the slot full
    always_comb begin
        stateNext_s = state_r;
        if (iFlush) begin
            stateNext_s = IDLE;
        end else if (accept_s) begin
            stateNext_s = RESP;
        end else if (complete_s) begin
            stateNext_s = IDLE;
        end else begin
            stateNext_s = state_r;
        end
    end

    // state, pointer, response id and completion counter
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            oRspId   <= '0;
            oDoneCnt <= 16'd0;
        end else begin
            state_r <= stateNext_s;
            if (accept_s) begin
                ptr_r  <= grantIdx_s + IDW'(1);
                oRspId <= grantIdx_s;
            end else begin
                ptr_r  <= ptr_r;
                oRspId <= oRspId;
            end
            if (complete_s) begin
                oDoneCnt <= oDoneCnt + 16'd1;
            end else begin
                oDoneCnt <= oDoneCnt;
            end
        end
    end

    assign oRspValid = (state_r == RESP);
    assign oBusy     = (state_r == RESP);

    multiplier_reg #(
        .BITWIDTH (BITWIDTH)
    ) uMul (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (accept_s),
        .iClr  (iFlush),
        .iA    (opA_s),
        .iB    (opB_s),
        .oProd (oRspData)
    );

endmodule
